// File: rtl/bus_pkg.sv
// Shared master identifiers, request encodings and arbiter state type
// for the like-SRAM bus arbiter.
package bus_pkg;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int REQ_SIZE_BITS = 2;
  localparam int REQ_STRB_BITS = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCK
  } arb_state_e;

  // Width-independent control fields of a like-SRAM request.
  typedef struct packed {
    logic                     wr;
    logic [REQ_SIZE_BITS-1:0] size;
    logic [REQ_STRB_BITS-1:0] wstrb;
  } req_ctrl_t;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order tracker of which master issued each accepted-but-unanswered
// transaction; one bit per entry.
module arb_id_fifo #(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             push_id,
  input  logic             pop,
  output logic             head_id,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // The owner never pushes when full nor pops when empty, so no guards here.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      mem_d[wptr_q] = push_id;
      wptr_d        = ptr_next(wptr_q);
    end
    if (pop) begin
      rptr_d = ptr_next(rptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head_id = mem_q[rptr_q];
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one like-SRAM slave port between the instruction-fetch master (M0)
// and the data master (M1), routing in-order responses back to their issuer.
module sram_bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_OUTS   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [1:0]        m0_size,
  input  logic [3:0]        m0_wstrb,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_addr_ok,
  output logic              m0_data_ok,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [1:0]        m1_size,
  input  logic [3:0]        m1_wstrb,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_addr_ok,
  output logic              m1_data_ok,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_req,
  output logic              s_wr,
  output logic [1:0]        s_size,
  output logic [3:0]        s_wstrb,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_addr_ok,
  input  logic              s_data_ok,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              proto_err
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int TRK_CNT_W = $clog2(MAX_OUTS + 1);

  arb_state_e          state_q, state_d;
  logic                lock_id_q, lock_id_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                proto_err_q, proto_err_d;

  logic                 grant_valid;
  logic                 grant_id;
  logic                 accept;
  logic                 pop;
  logic                 head_id;
  logic                 trk_full;
  logic                 trk_empty;
  logic [TRK_CNT_W-1:0] trk_count;
  req_ctrl_t            sel_ctrl;

  arb_id_fifo #(
    .DEPTH (MAX_OUTS)
  ) u_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (accept),
    .push_id (grant_id),
    .pop     (pop),
    .head_id (head_id),
    .full    (trk_full),
    .empty   (trk_empty),
    .count   (trk_count)
  );

  // A grant held in LOCK ignores both the tracker level and the starvation
  // override: the slave has already seen that request and must get it unchanged.
  always_comb begin
    state_d      = state_q;
    lock_id_d    = lock_id_q;
    starve_cnt_d = starve_cnt_q;
    grant_valid  = 1'b0;
    grant_id     = ID_DATA;

    if (state_q == ARB_LOCK) begin
      grant_valid = 1'b1;
      grant_id    = lock_id_q;
    end else if (!trk_full) begin
      if (m0_req && (starve_cnt_q == STARVE_W'(STARVE_MAX))) begin
        grant_valid = 1'b1;
        grant_id    = ID_INST;
      end else if (m1_req) begin
        grant_valid = 1'b1;
        grant_id    = ID_DATA;
      end else if (m0_req) begin
        grant_valid = 1'b1;
        grant_id    = ID_INST;
      end
    end
    if (reset) begin
      grant_valid = 1'b0;
    end

    accept = grant_valid & s_addr_ok;

    if ((state_q == ARB_IDLE) && grant_valid && !s_addr_ok) begin
      state_d   = ARB_LOCK;
      lock_id_d = grant_id;
    end else if ((state_q == ARB_LOCK) && s_addr_ok) begin
      state_d = ARB_IDLE;
    end

    if ((accept && (grant_id == ID_INST)) || !m0_req) begin
      starve_cnt_d = '0;
    end else if (accept && (starve_cnt_q != STARVE_W'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end
  end

  always_comb begin
    sel_ctrl = (grant_id == ID_INST) ? req_ctrl_t'{m0_wr, m0_size, m0_wstrb}
                                     : req_ctrl_t'{m1_wr, m1_size, m1_wstrb};
    s_req    = grant_valid;
    s_wr     = sel_ctrl.wr;
    s_size   = sel_ctrl.size;
    s_wstrb  = sel_ctrl.wstrb;
    s_addr   = (grant_id == ID_INST) ? m0_addr : m1_addr;
    s_wdata  = (grant_id == ID_INST) ? m0_wdata : m1_wdata;
  end

  // A response can only belong to a transaction accepted in an earlier cycle,
  // so popping is gated on the pre-push tracker level.
  always_comb begin
    pop         = s_data_ok & !trk_empty & !reset;
    proto_err_d = proto_err_q | (s_data_ok & (trk_count == '0));
    m0_addr_ok  = accept & (grant_id == ID_INST);
    m1_addr_ok  = accept & (grant_id == ID_DATA);
    m0_data_ok  = pop & (head_id == ID_INST);
    m1_data_ok  = pop & (head_id == ID_DATA);
    m0_rdata    = m0_data_ok ? s_rdata : '0;
    m1_rdata    = m1_data_ok ? s_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      lock_id_q    <= ID_INST;
      starve_cnt_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_id_q    <= lock_id_d;
      starve_cnt_q <= starve_cnt_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: directed vector table, hand-built
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_sram_bus_arbiter;

  localparam int MAX_OUTS   = 2;
  localparam int STARVE_MAX = 4;
  localparam logic [31:0] A0 = 32'h1c00_0000;
  localparam logic [31:0] A1 = 32'h1c00_0100;

  logic clk = 1'b0;
  logic reset;
  logic m0_req, m0_wr, m1_req, m1_wr;
  logic [1:0] m0_size, m1_size;
  logic [3:0] m0_wstrb, m1_wstrb;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
  logic [31:0] m0_rdata, m1_rdata;
  logic s_req, s_wr;
  logic [1:0] s_size;
  logic [3:0] s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;
  logic proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_OUTS(MAX_OUTS), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_wstrb(m0_wstrb),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok),
    .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_wstrb(m1_wstrb),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok),
    .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok),
    .s_data_ok(s_data_ok), .s_rdata(s_rdata), .proto_err(proto_err)
  );

  // Reference model: ordered list of issuer ids, the master whose request the
  // slave is currently looking at (-1 = none), starvation count, sticky error.
  int mdl_q[$];
  int mdl_lock;
  int mdl_starve;
  bit mdl_perr;

  logic exp_s_req;
  int exp_gid;
  logic exp_m0_aok, exp_m1_aok, exp_m0_dok, exp_m1_dok;
  logic [31:0] exp_m0_rdata, exp_m1_rdata;
  logic exp_perr;

  function void model_reset();
    mdl_q.delete();
    mdl_lock   = -1;
    mdl_starve = 0;
    mdl_perr   = 1'b0;
  endfunction

  function void model_eval();
    exp_s_req = 1'b0;
    exp_gid   = 1;
    if (mdl_lock >= 0) begin
      exp_s_req = 1'b1;
      exp_gid   = mdl_lock;
    end else if (mdl_q.size() < MAX_OUTS) begin
      if (m0_req && mdl_starve == STARVE_MAX) begin
        exp_s_req = 1'b1; exp_gid = 0;
      end else if (m1_req) begin
        exp_s_req = 1'b1; exp_gid = 1;
      end else if (m0_req) begin
        exp_s_req = 1'b1; exp_gid = 0;
      end
    end
    exp_m0_aok   = exp_s_req && s_addr_ok && exp_gid == 0;
    exp_m1_aok   = exp_s_req && s_addr_ok && exp_gid == 1;
    exp_m0_dok   = s_data_ok && mdl_q.size() > 0 && mdl_q[0] == 0;
    exp_m1_dok   = s_data_ok && mdl_q.size() > 0 && mdl_q[0] == 1;
    exp_m0_rdata = exp_m0_dok ? s_rdata : 32'h0;
    exp_m1_rdata = exp_m1_dok ? s_rdata : 32'h0;
    exp_perr     = mdl_perr;
  endfunction

  function void model_commit();
    if (s_data_ok) begin
      if (mdl_q.size() == 0) mdl_perr = 1'b1;
      else void'(mdl_q.pop_front());
    end
    if (exp_s_req && s_addr_ok) begin
      mdl_q.push_back(exp_gid);
      mdl_lock = -1;
    end else if (exp_s_req) begin
      mdl_lock = exp_gid;
    end
    if ((exp_m0_aok) || !m0_req) mdl_starve = 0;
    else if (exp_m1_aok && mdl_starve < STARVE_MAX) mdl_starve++;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic r1, input logic aok,
                               input logic dok, input logic [31:0] rd);
    m0_req = r0; m1_req = r1; s_addr_ok = aok; s_data_ok = dok; s_rdata = rd;
    model_eval();
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m0_req = 1'b0; m1_req = 1'b1; s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'h0;
    @(negedge clk);
    checkOutput("rst_s_req", s_req, 0);
    checkOutput("rst_m1_aok", m1_addr_ok, 0);
    checkOutput("rst_m1_dok", m1_data_ok, 0);
    @(posedge clk); #1;
    reset = 1'b0; m1_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
    model_reset();
    @(negedge clk);
    checkOutput("rst_perr", proto_err, 0);
    checkOutput("rst_idle_s_req", s_req, 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic r0, r1, aok, dok;
    logic [31:0] rd;
    logic e_s_req;
    logic [31:0] e_s_addr;
    logic e_m0_aok, e_m1_aok, e_m0_dok, e_m1_dok;
    logic [31:0] e_m0_rd, e_m1_rd;
    logic e_perr;
  } vec_t;

  vec_t vecs[8];
  int exp_seq[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  logic p0, p1;

  initial begin
    m0_wr = 1'b0; m1_wr = 1'b0; m0_size = SIZE_CODE_W(); m1_size = 2'd2;
    m0_wstrb = 4'hf; m1_wstrb = 4'hf; m0_wdata = 32'h0; m1_wdata = 32'h0;
    m0_addr = A0; m1_addr = A1;
    model_reset();
    do_reset();

    // M1 read answered two cycles later, then M0/M1 contention with in-order responses.
    vecs[0] = '{0, 1, 1, 0, 32'h0,        1, A1, 0, 1, 0, 0, 32'h0, 32'h0, 0};
    vecs[1] = '{0, 0, 0, 0, 32'h5555_5555, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0};
    vecs[2] = '{0, 0, 0, 1, 32'hdeadbeef, 0, 32'h0, 0, 0, 0, 1, 32'h0, 32'hdeadbeef, 0};
    vecs[3] = '{1, 1, 1, 0, 32'h0,        1, A1, 0, 1, 0, 0, 32'h0, 32'h0, 0};
    vecs[4] = '{1, 0, 1, 0, 32'h0,        1, A0, 1, 0, 0, 0, 32'h0, 32'h0, 0};
    vecs[5] = '{0, 0, 0, 1, 32'h1111_1111, 0, 32'h0, 0, 0, 0, 1, 32'h0, 32'h1111_1111, 0};
    vecs[6] = '{0, 0, 0, 1, 32'h2222_2222, 0, 32'h0, 0, 0, 1, 0, 32'h2222_2222, 32'h0, 0};
    vecs[7] = '{0, 0, 0, 0, 32'h0,        0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].r0, vecs[i].r1, vecs[i].aok, vecs[i].dok, vecs[i].rd);
      checkOutput($sformatf("vec%0d_s_req", i), s_req, vecs[i].e_s_req);
      if (vecs[i].e_s_req) checkOutput($sformatf("vec%0d_s_addr", i), s_addr, vecs[i].e_s_addr);
      checkOutput($sformatf("vec%0d_m0_aok", i), m0_addr_ok, vecs[i].e_m0_aok);
      checkOutput($sformatf("vec%0d_m1_aok", i), m1_addr_ok, vecs[i].e_m1_aok);
      checkOutput($sformatf("vec%0d_m0_dok", i), m0_data_ok, vecs[i].e_m0_dok);
      checkOutput($sformatf("vec%0d_m1_dok", i), m1_data_ok, vecs[i].e_m1_dok);
      checkOutput($sformatf("vec%0d_m0_rd", i), m0_rdata, vecs[i].e_m0_rd);
      checkOutput($sformatf("vec%0d_m1_rd", i), m1_rdata, vecs[i].e_m1_rd);
      checkOutput($sformatf("vec%0d_perr", i), proto_err, vecs[i].e_perr);
      step();
    end

    // M1 held off by the slave while M0 starts requesting: grant stays locked on M1.
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("lock_s_req", s_req, 1); checkOutput("lock_addr0", s_addr, A1);
    checkOutput("lock_m1_aok0", m1_addr_ok, 0); step();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, 0, 0, 0);
      checkOutput("lock_addr_wait", s_addr, A1); checkOutput("lock_m0_aok_wait", m0_addr_ok, 0);
      step();
    end
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("lock_addr_acc", s_addr, A1); checkOutput("lock_m1_aok", m1_addr_ok, 1);
    checkOutput("lock_m0_aok", m0_addr_ok, 0); step();
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("lock_m0_addr", s_addr, A0); checkOutput("lock_m0_grant", m0_addr_ok, 1); step();
    applyStimulus(0, 0, 0, 1, 32'h3333_3333);
    checkOutput("lock_resp_m1", m1_data_ok, 1); checkOutput("lock_resp_m1_rd", m1_rdata, 32'h3333_3333); step();
    applyStimulus(0, 0, 0, 1, 32'h4444_4444);
    checkOutput("lock_resp_m0", m0_data_ok, 1); checkOutput("lock_resp_m0_rd", m0_rdata, 32'h4444_4444); step();

    // Tracker full: grant withheld, and a same-cycle response does not release it.
    applyStimulus(0, 1, 1, 0, 0); checkOutput("full_acc1", m1_addr_ok, 1); step();
    applyStimulus(0, 1, 1, 0, 0); checkOutput("full_acc2", m1_addr_ok, 1); step();
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("full_s_req", s_req, 0); checkOutput("full_m1_aok", m1_addr_ok, 0);
    checkOutput("full_m0_aok", m0_addr_ok, 0); step();
    applyStimulus(1, 1, 1, 1, 32'h5a5a_0001);
    checkOutput("full_pop_s_req", s_req, 0); checkOutput("full_pop_dok", m1_data_ok, 1); step();
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("full_resume_s_req", s_req, 1); checkOutput("full_resume_m1", m1_addr_ok, 1); step();
    applyStimulus(0, 0, 0, 1, 32'h5a5a_0002); checkOutput("full_drain1", m1_data_ok, 1); step();
    applyStimulus(0, 0, 0, 1, 32'h5a5a_0003); checkOutput("full_drain2", m1_data_ok, 1); step();

    // Continuous contention: M0 forced in after STARVE_MAX M1 grants.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, 1, i > 0, 32'h100 + i);
      checkOutput($sformatf("starve%0d_m1", i), m1_addr_ok, exp_seq[i] == 1);
      checkOutput($sformatf("starve%0d_m0", i), m0_addr_ok, exp_seq[i] == 0);
      if (i > 0) checkOutput($sformatf("starve%0d_m0_dok", i), m0_data_ok, exp_seq[i-1] == 0);
      step();
    end
    applyStimulus(0, 0, 0, 1, 32'h0); checkOutput("starve_drain", m0_data_ok, 1); step();

    // Spurious response sets a sticky error; reset clears it and the tracker.
    applyStimulus(0, 0, 0, 1, 32'haaaa_aaaa);
    checkOutput("perr_m0_dok", m0_data_ok, 0); checkOutput("perr_m1_dok", m1_data_ok, 0); step();
    applyStimulus(0, 0, 0, 0, 0); checkOutput("perr_set", proto_err, 1); step();
    applyStimulus(0, 0, 0, 0, 0); checkOutput("perr_held", proto_err, 1); step();
    applyStimulus(0, 1, 1, 0, 0); step();
    applyStimulus(0, 1, 1, 0, 0); step();
    do_reset();
    applyStimulus(0, 0, 0, 1, 32'hbbbb_bbbb); checkOutput("rst_trk_empty", m1_data_ok, 0); step();
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("rst_perr_again", proto_err, 1); checkOutput("rst_grant", m1_addr_ok, 1); step();

    // Randomized traffic against the model.
    do_reset();
    p0 = 1'b0; p1 = 1'b0;
    for (int c = 0; c < 500; c++) begin
      logic aok, dok;
      if (!p0 && $urandom_range(2) == 0) begin
        p0 = 1'b1; m0_addr = $urandom; m0_size = 2'($urandom_range(2));
        m0_wstrb = 4'($urandom); m0_wdata = $urandom;
      end
      if (!p1 && $urandom_range(2) == 0) begin
        p1 = 1'b1; m1_addr = $urandom; m1_size = 2'($urandom_range(2));
        m1_wr = 1'($urandom); m1_wstrb = 4'($urandom); m1_wdata = $urandom;
      end
      aok = 1'($urandom_range(1));
      dok = (mdl_q.size() > 0) ? 1'($urandom_range(1)) : ($urandom_range(60) == 0);
      applyStimulus(p0, p1, aok, dok, $urandom);
      checkOutput("rnd_s_req", s_req, exp_s_req);
      if (exp_s_req) begin
        checkOutput("rnd_s_addr", s_addr, (exp_gid == 0) ? m0_addr : m1_addr);
        checkOutput("rnd_s_wr", s_wr, (exp_gid == 0) ? m0_wr : m1_wr);
        checkOutput("rnd_s_size", s_size, (exp_gid == 0) ? m0_size : m1_size);
        checkOutput("rnd_s_wstrb", s_wstrb, (exp_gid == 0) ? m0_wstrb : m1_wstrb);
        checkOutput("rnd_s_wdata", s_wdata, (exp_gid == 0) ? m0_wdata : m1_wdata);
      end
      checkOutput("rnd_m0_aok", m0_addr_ok, exp_m0_aok);
      checkOutput("rnd_m1_aok", m1_addr_ok, exp_m1_aok);
      checkOutput("rnd_m0_dok", m0_data_ok, exp_m0_dok);
      checkOutput("rnd_m1_dok", m1_data_ok, exp_m1_dok);
      checkOutput("rnd_m0_rd", m0_rdata, exp_m0_rdata);
      checkOutput("rnd_m1_rd", m1_rdata, exp_m1_rdata);
      checkOutput("rnd_perr", proto_err, exp_perr);
      if (exp_m0_aok) p0 = 1'b0;
      if (exp_m1_aok) p1 = 1'b0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [1:0] SIZE_CODE_W();
    return 2'd2;
  endfunction

endmodule
